bomb_place_arbiter: RTL and testbench

- Arbitrates bomb-placement requests from player A and player B and issues single-cell writes into the shared bomb map. The bomb map advances each cell 1→2→3→explode on the bomb tick.
- Checks each request against the target cell's current bomb state and the player's bomb budget.
- Tracks each player's in-flight bombs with fuse counters that advance on the bomb tick.
- Sits between the player input logic and the bomb-map register file, on the system clock.

---
 rtl/bomb_place_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bomb_place_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_place_arbiter.sv
// Bomb placement arbiter: captures place requests from two players, arbitrates
// round-robin, validates the target cell and the player's bomb budget, issues a
// single-cell write into the bomb map and tracks in-flight bombs with fuse
// counters that advance on the bomb tick. Index 0 is player A, index 1 is B.
module bomb_place_arbiter #(
  parameter int MAP_DIM    = 10,
  parameter int MAX_BOMBS  = 2,
  parameter int FUSE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       reqA,
  input  logic [3:0] xA,
  input  logic [3:0] yA,
  input  logic       reqB,
  input  logic [3:0] xB,
  input  logic [3:0] yB,
  output logic [3:0] rd_x,
  output logic [3:0] rd_y,
  input  logic [1:0] rd_state,
  output logic       wr_en,
  output logic [3:0] wr_x,
  output logic [3:0] wr_y,
  output logic       ackA,
  output logic       nackA,
  output logic       ackB,
  output logic       nackB,
  output logic [1:0] bombsA,
  output logic [1:0] bombsB
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, RESP_ACK, RESP_NACK} state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    pend_q, pend_d;       // per-player pending request
  logic [1:0][3:0]               px_q, px_d, py_q, py_d; // captured coordinates
  logic                          sel_q, sel_d;         // player being served
  logic [3:0]                    sx_q, sx_d, sy_q, sy_d; // coordinates being served
  logic                          rr_q, rr_d;           // round-robin: 0 favours A
  logic [1:0][MAX_BOMBS-1:0][1:0] fuse_q, fuse_d;      // 0 means slot free
  logic [1:0][1:0]               cnt_q, cnt_d;         // in-flight bombs per player

  logic [1:0]      req;
  logic [1:0][3:0] xin, yin;
  logic            reject;

  assign req = {reqB, reqA};
  assign xin = {xB, xA};
  assign yin = {yB, yA};

  // A request is refused for an off-map cell, an occupied cell or an exhausted
  // budget; the budget uses the pre-edge count so a same-edge release cannot help.
  assign reject = (int'(sx_q) >= MAP_DIM) || (int'(sy_q) >= MAP_DIM) ||
                  (rd_state != 2'd0) || (int'(cnt_q[sel_q]) >= MAX_BOMBS);

  // Request capture: latch coordinates on a new request, clear once responded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    pend_d = pend_q;
    px_d   = px_q;
    py_d   = py_q;
    for (int p = 0; p < 2; p++) begin
      if ((state_q == RESP_ACK || state_q == RESP_NACK) && (int'(sel_q) == p)) begin
        pend_d[p] = 1'b0;
      end else if (req[p] && !pend_q[p]) begin
        pend_d[p] = 1'b1;
        px_d[p]   = xin[p];
        py_d[p]   = yin[p];
      end
    end
  end

  // FSM next-state: select, check, write, respond.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          sel_d   = (pend_q == 2'b11) ? rr_q : pend_q[1];
          sx_d    = px_q[sel_d];
          sy_d    = py_q[sel_d];
          state_d = CHECK;
        end
      end
      CHECK:     state_d = reject ? RESP_NACK : WRITE;
      WRITE:     state_d = RESP_ACK;
      RESP_ACK,
      RESP_NACK: begin
        rr_d    = ~sel_q;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Fuse slots: decrement on tick, release at zero, load a free slot on WRITE exit.
  always_comb begin
    logic [1:0] rel;
    logic       load;
    fuse_d = fuse_q;
    cnt_d  = cnt_q;
    for (int p = 0; p < 2; p++) begin
      rel  = 2'd0;
      load = 1'b0;
      for (int s = 0; s < MAX_BOMBS; s++) begin
        if (tick && fuse_q[p][s] != 2'd0) begin
          fuse_d[p][s] = fuse_q[p][s] - 2'd1;
          if (fuse_q[p][s] == 2'd1) rel = rel + 2'd1;
        end
      end
      // A freshly loaded slot overrides any tick decrement on the same edge.
      if (state_q == WRITE && int'(sel_q) == p) begin
        for (int s = 0; s < MAX_BOMBS; s++) begin
          if (!load && fuse_q[p][s] == 2'd0) begin
            fuse_d[p][s] = 2'(FUSE_TICKS);
            load         = 1'b1;
          end
        end
      end
      cnt_d[p] = cnt_q[p] - rel + {1'b0, load};
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      sel_q   <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      rr_q    <= 1'b0;
      // NOTE: the fuse array is tiny and its zero value means "slot free", so
      // unlike a bulk memory it must be reset.
      fuse_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pend_q  <= pend_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sel_q   <= sel_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      rr_q    <= rr_d;
      fuse_q  <= fuse_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from the current state; all zero outside their state.
  assign rd_x   = (state_q == CHECK) ? sx_q : 4'd0;
  assign rd_y   = (state_q == CHECK) ? sy_q : 4'd0;
  assign wr_en  = (state_q == WRITE);
  assign wr_x   = (state_q == WRITE) ? sx_q : 4'd0;
  assign wr_y   = (state_q == WRITE) ? sy_q : 4'd0;
  assign ackA   = (state_q == RESP_ACK)  && !sel_q;
  assign ackB   = (state_q == RESP_ACK)  &&  sel_q;
  assign nackA  = (state_q == RESP_NACK) && !sel_q;
  assign nackB  = (state_q == RESP_NACK) &&  sel_q;
  assign bombsA = cnt_q[0];
  assign bombsB = cnt_q[1];

endmodule

// File: tb/tb_bomb_place_arbiter.sv
// Directed bench for bomb_place_arbiter: placement latency, arbitration order,
// rejection causes, budget and fuse expiry, same-edge tick/load and reset abort.
module tb_bomb_place_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       reqA = 1'b0, reqB = 1'b0;
  logic [3:0] xA = '0, yA = '0, xB = '0, yB = '0;
  logic [3:0] rd_x, rd_y, wr_x, wr_y;
  logic [1:0] rd_state = 2'd0;
  logic       wr_en, ackA, nackA, ackB, nackB;
  logic [1:0] bombsA, bombsB;

  int total = 0;
  int bad   = 0;

  bomb_place_arbiter #(.MAP_DIM(10), .MAX_BOMBS(2), .FUSE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .reqA(reqA), .xA(xA), .yA(yA),
    .reqB(reqB), .xB(xB), .yB(yB),
    .rd_x(rd_x), .rd_y(rd_y), .rd_state(rd_state),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .ackA(ackA), .nackA(nackA), .ackB(ackB), .nackB(nackB),
    .bombsA(bombsA), .bombsB(bombsB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_ack_nack", int'({ackA, nackA, ackB, nackB}), 0);
    check("rst_bombs", int'({bombsA, bombsB}), 0);
    check("rst_rd_x", int'(rd_x), 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Single A placement at (3,4)
    reqA = 1'b1; xA = 4'd3; yA = 4'd4;
    cyc();                                   // edge 0: captured
    reqA = 1'b0;
    check("t1_idle_wr_en", int'(wr_en), 0);
    cyc();                                   // edge 1: CHECK
    check("t1_rd_x", int'(rd_x), 3);
    check("t1_rd_y", int'(rd_y), 4);
    check("t1_chk_wr_en", int'(wr_en), 0);
    cyc();                                   // edge 2: WRITE
    check("t1_wr_en", int'(wr_en), 1);
    check("t1_wr_xy", int'({wr_x, wr_y}), 8'h34);
    cyc();                                   // edge 3: RESP_ACK
    check("t1_ackA", int'(ackA), 1);
    check("t1_ack_wr_en", int'(wr_en), 0);
    check("t1_bombsA", int'(bombsA), 1);
    cyc();
    check("t1_ackA_drop", int'(ackA), 0);

    // A off-map column -> nackA (pointer moves to B)
    reqA = 1'b1; xA = 4'd10; yA = 4'd0;
    cyc();
    reqA = 1'b0;
    cyc();
    check("t3a_chk_wr_en", int'(wr_en), 0);
    cyc();
    check("t3a_nackA", int'(nackA), 1);
    check("t3a_ackA", int'(ackA), 0);
    check("t3a_wr_en", int'(wr_en), 0);
    cyc();
    check("t3a_bombsA", int'(bombsA), 1);

    // B target occupied (state 2) -> nackB (pointer moves to A)
    rd_state = 2'd2;
    reqB = 1'b1; xB = 4'd1; yB = 4'd1;
    cyc();
    reqB = 1'b0;
    cyc();
    check("t3b_rd_x", int'(rd_x), 1);
    cyc();
    check("t3b_nackB", int'(nackB), 1);
    check("t3b_wr_en", int'(wr_en), 0);
    cyc();
    check("t3b_bombsB", int'(bombsB), 0);
    rd_state = 2'd0;

    // Simultaneous pair with pointer at A: A then B
    reqA = 1'b1; xA = 4'd2; yA = 4'd2;
    reqB = 1'b1; xB = 4'd5; yB = 4'd5;
    cyc();
    reqA = 1'b0; reqB = 1'b0;
    cyc();
    check("t2_rd_first", int'(rd_x), 2);
    cyc();
    check("t2_wr_first", int'({wr_en, wr_x, wr_y}), 9'h122);
    cyc();
    check("t2_ackA", int'({ackA, ackB}), 2'b10);
    check("t2_bombsA", int'(bombsA), 2);
    cyc();                                   // IDLE
    cyc();
    check("t2_rd_second", int'(rd_x), 5);
    cyc();
    check("t2_wr_second", int'({wr_en, wr_x, wr_y}), 9'h155);
    cyc();
    check("t2_ackB", int'({ackA, ackB}), 2'b01);
    check("t2_bombsB", int'(bombsB), 1);
    cyc();

    // A at budget -> nackA even for a free in-range cell (pointer moves to B)
    reqA = 1'b1; xA = 4'd6; yA = 4'd6;
    cyc();
    reqA = 1'b0;
    cyc();
    check("t4_chk_wr_en", int'(wr_en), 0);
    cyc();
    check("t4_nackA_budget", int'(nackA), 1);
    check("t4_wr_en", int'(wr_en), 0);
    cyc();

    // Pair with pointer at B: B served first, then A rejected on budget
    reqA = 1'b1; xA = 4'd7; yA = 4'd7;
    reqB = 1'b1; xB = 4'd8; yB = 4'd8;
    cyc();
    reqA = 1'b0; reqB = 1'b0;
    cyc();
    check("t2b_rd_first", int'(rd_x), 8);
    cyc();
    check("t2b_wr_first", int'({wr_en, wr_x, wr_y}), 9'h188);
    cyc();
    check("t2b_ackB", int'(ackB), 1);
    check("t2b_bombsB", int'(bombsB), 2);
    cyc();
    cyc();
    check("t2b_rd_second", int'(rd_x), 7);
    cyc();
    check("t2b_nackA", int'({nackA, wr_en}), 2'b10);
    cyc();

    // Three ticks expire every bomb
    tick_pulse();
    tick_pulse();
    check("t4_two_ticks", int'({bombsA, bombsB}), 4'b1010);
    tick_pulse();
    check("t4_three_ticks", int'({bombsA, bombsB}), 0);

    // Budget restored: new A placement accepted
    reqA = 1'b1; xA = 4'd3; yA = 4'd4;
    cyc();
    reqA = 1'b0;
    cyc(); cyc(); cyc();
    check("t4_ack_after_expiry", int'(ackA), 1);
    check("t4_bombsA_one", int'(bombsA), 1);
    cyc();

    // Age that bomb to fuse 1, then place another with tick on the WRITE exit edge
    tick_pulse();
    tick_pulse();
    check("t5_pre_bombsA", int'(bombsA), 1);
    reqA = 1'b1; xA = 4'd4; yA = 4'd4;
    cyc();
    reqA = 1'b0;
    cyc();
    cyc();
    check("t5_wr_en", int'(wr_en), 1);
    tick = 1'b1;
    cyc();                                   // release + load on same edge
    tick = 1'b0;
    check("t5_ackA", int'(ackA), 1);
    check("t5_bombsA_net0", int'(bombsA), 1);
    cyc();
    tick_pulse();
    tick_pulse();
    check("t5_fuse_still_live", int'(bombsA), 1);
    tick_pulse();
    check("t5_fuse_expired", int'(bombsA), 0);

    // Reset asserted during WRITE drops the transaction
    reqA = 1'b1; xA = 4'd5; yA = 4'd5;
    cyc();
    reqA = 1'b0;
    cyc();
    cyc();
    check("t6_wr_en_before", int'(wr_en), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_wr_en_drop", int'(wr_en), 0);
    check("t6_bombsA", int'(bombsA), 0);
    cyc();
    check("t6_no_resp_in_rst", int'({ackA, nackA}), 0);
    rst = 1'b0;
    cyc();
    check("t6_no_resp_after", int'({ackA, nackA, wr_en}), 0);
    cyc();
    check("t6_still_quiet", int'({ackA, nackA, wr_en, bombsA}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
